hazard_scoreboard_ctrl: RTL and testbench
=========================================

Name: hazard_scoreboard_ctrl

Overview:
- Tracks every in-flight GRF write through the E, M and W stages of the 5-stage pipeline.
- Uses a per-stage record of destination register, remaining Tnew and write-data source.
- Drives the D-stage stall, the forwarding selects for D- and E-stage operands, and the M-stage write-data source select.
- Sits beside the pipeline registers and is the single owner of hazard decisions.

Parameters:
- REG_W, 5, GRF address width.
- TNEW_W, 2, width of Tnew/Tuse fields.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- D_valid  in  1  D stage holds a real instruction
- D_rs  in  REG_W  D-stage rs address
- D_rt  in  REG_W  D-stage rt address
- D_Tuse_rs  in  TNEW_W  cycles after D until rs value is consumed (0..2; 3 = unused)
- D_Tuse_rt  in  TNEW_W  same for rt
- D_A3  in  REG_W  D-stage destination register (0 = no write)
- D_Tnew  in  TNEW_W  cycles after entering E until result ready (ALU 1, load 2, jal/link 0)
- D_src  in  2  write-data source: 00 ALU ans, 01 mem Rdata, 10 link (adder+4)
- stall  out  1  freeze PC/D register, bubble E
- fwd_D_rs  out  2  00 GRF, 01 from E, 10 from M, 11 from W
- fwd_D_rt  out  2  same encoding
- fwd_E_rs  out  2  00 none, 10 from M, 11 from W (01 never driven)
- fwd_E_rt  out  2  same
- s_M_GRF_Wdata  out  2  M record src, drives the M-stage write-data mux
- W_we  out  1  W record valid and A3 != 0
- W_A3  out  REG_W  W destination

Behaviour:
- State: records E, M, W, each holding {valid, A3, Tnew, src}. The E record also holds rs and rt.
- Reset (async, reset==0): all records cleared (valid=0, fields 0). Outputs then read stall=0, all fwd=00, s_M_GRF_Wdata=00, W_we=0, W_A3=0. Reset mid-stall drops stall immediately, without waiting for a clock edge.
- Advance (posedge clk, reset==1):
  - W <= M.
  - M <= E with Tnew decremented, saturating at 0.
  - E <= D fields if stall==0 and D_valid. Otherwise E <= bubble (valid=0, A3=0, rs=rt=0, Tnew=0).
- Match rule: a stage matches operand r when valid, A3==r and r!=0. $0 never stalls and never forwards.
- stall (combinational) is 1 if any of the following hold for rs (Tuse_rs) or rt (Tuse_rt), with D_valid=1:
  - The E record matches and Tuse < E.Tnew.
  - The M record matches and Tuse < M.Tnew.
  - W is never a stall source.
- fwd_D_x (combinational):
  - Priority is E > M > W.
  - The first matching stage wins. If that stage's Tnew != 0, output 00; the stall covers it.
  - E is eligible only with E.Tnew==0 (link).
  - M is eligible only with M.Tnew==0.
  - W is always eligible.
  - No match gives 00.
- fwd_E_x: uses the stored E.rs/E.rt. Priority is M (Tnew==0) > W. Returns 00 on no eligible match or on a bubble.
- All outputs except stall/fwd are pure register decodes, with 0-cycle latency from state.
- A stall lasts at most 2 cycles per hazard, since Tnew decreases by 1 per cycle.
- The upstream Tuse=3 encoding means "not read" and can never stall.
- Simultaneous matches at E and M on the same register: E wins (youngest writer).

Test Plan:
- Load-use: lw $8 (Tnew 2, src 01), then addu reading $8 (Tuse 1).
  - Cycle with lw in E: stall=1 for exactly 1 cycle.
  - Next cycle: stall=0.
  - Next cycle: addu in E, lw in W, fwd_E_rs=11.
- ALU-to-branch: addu $9 (Tnew 1), then beq on $9 (Tuse 0).
  - stall=1 for 1 cycle.
  - Then addu in M, fwd_D_rs=10, s_M_GRF_Wdata=00.
- Link: jal (A3=31, Tnew 0, src 10), then jr $31 (Tuse 0).
  - No stall, fwd_D_rs=01.
  - Next cycle s_M_GRF_Wdata=10; following cycle W_we=1, W_A3=31.
- $0 target: lw $0 followed by a use of $0 → stall=0, all fwd=00, W_we=0.
- Priority: addu $5 then ori $5, then a D-stage reader of $5 with Tuse 1.
  - With ori in E (Tnew 1) and addu in M (Tnew 0): no stall, fwd_D_rs=00 (E wins, not yet ready).
  - Next cycle: fwd_D_rs=10 from ori.
- Async reset: assert reset=0 between clock edges during a lw stall.
  - stall falls to 0 immediately, all records clear.
  - After release, the first instruction enters E cleanly.

Source files
------------

// File: rtl/hazard_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_ctrl: E/M/W write scoreboard driving the D-stage stall,
// the D/E operand forwarding selects and the M/W write-back controls.
// Revision: 1.0
// ============================================================================
module hazard_scoreboard_ctrl #(
    parameter int REG_W  = 5,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              D_valid,
    input  logic [REG_W-1:0]  D_rs,
    input  logic [REG_W-1:0]  D_rt,
    input  logic [TNEW_W-1:0] D_Tuse_rs,
    input  logic [TNEW_W-1:0] D_Tuse_rt,
    input  logic [REG_W-1:0]  D_A3,
    input  logic [TNEW_W-1:0] D_Tnew,
    input  logic [1:0]        D_src,
    output logic              stall,
    output logic [1:0]        fwd_D_rs,
    output logic [1:0]        fwd_D_rt,
    output logic [1:0]        fwd_E_rs,
    output logic [1:0]        fwd_E_rt,
    output logic [1:0]        s_M_GRF_Wdata,
    output logic              W_we,
    output logic [REG_W-1:0]  W_A3
);

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  a3;
        logic [TNEW_W-1:0] tnew;
        logic [1:0]        src;
    } rec_t;

    rec_t             e_rec, m_rec, w_rec, m_next;
    logic [REG_W-1:0] e_rs, e_rt;
    logic             issue;

    function automatic logic hit(input rec_t rec, input logic [REG_W-1:0] r);
        return rec.valid && (rec.a3 == r) && (r != '0);
    endfunction

    function automatic logic hazard(input logic [REG_W-1:0] r, input logic [TNEW_W-1:0] tuse);
        return (hit(e_rec, r) && (tuse < e_rec.tnew)) ||
               (hit(m_rec, r) && (tuse < m_rec.tnew));
    endfunction

    // Youngest matching writer decides; a not-yet-ready writer yields 00 and
    // relies on the stall rather than falling back to an older, stale copy.
    function automatic logic [1:0] fwd_d(input logic [REG_W-1:0] r);
        if (hit(e_rec, r))      return (e_rec.tnew == '0) ? 2'b01 : 2'b00;
        else if (hit(m_rec, r)) return (m_rec.tnew == '0) ? 2'b10 : 2'b00;
        else if (hit(w_rec, r)) return 2'b11;
        else                    return 2'b00;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [REG_W-1:0] r);
        if (!e_rec.valid)       return 2'b00;
        else if (hit(m_rec, r)) return (m_rec.tnew == '0) ? 2'b10 : 2'b00;
        else if (hit(w_rec, r)) return 2'b11;
        else                    return 2'b00;
    endfunction

    always_comb begin
        stall = D_valid && (hazard(D_rs, D_Tuse_rs) || hazard(D_rt, D_Tuse_rt));
        issue = D_valid && !stall;

        fwd_D_rs = fwd_d(D_rs);
        fwd_D_rt = fwd_d(D_rt);
        fwd_E_rs = fwd_e(e_rs);
        fwd_E_rt = fwd_e(e_rt);

        m_next      = e_rec;
        m_next.tnew = (e_rec.tnew != '0) ? e_rec.tnew - TNEW_W'(1) : '0;

        s_M_GRF_Wdata = m_rec.src;
        W_we          = w_rec.valid && (w_rec.a3 != '0);
        W_A3          = w_rec.a3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rec <= '0;
            m_rec <= '0;
            w_rec <= '0;
            e_rs  <= '0;
            e_rt  <= '0;
        end else begin
            w_rec <= m_rec;
            m_rec <= m_next;
            if (issue) begin
                e_rec <= '{valid: 1'b1, a3: D_A3, tnew: D_Tnew, src: D_src};
                e_rs  <= D_rs;
                e_rt  <= D_rt;
            end else begin
                e_rec <= '0;
                e_rs  <= '0;
                e_rt  <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_scoreboard_ctrl: directed bench with an instruction-history model.
// Revision: 1.0
// ============================================================================
module tb_hazard_scoreboard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       D_valid = 1'b0;
    logic [4:0] D_rs = '0, D_rt = '0, D_A3 = '0;
    logic [1:0] D_Tuse_rs = 2'd3, D_Tuse_rt = 2'd3, D_Tnew = '0, D_src = '0;
    logic       stall, W_we;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, s_M_GRF_Wdata;
    logic [4:0] W_A3;

    int checks = 0;
    int failures = 0;

    hazard_scoreboard_ctrl #(.REG_W(5), .TNEW_W(2)) dut (
        .clk(clk), .reset(reset), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
        .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_A3(D_A3), .D_Tnew(D_Tnew),
        .D_src(D_src), .stall(stall), .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
        .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .s_M_GRF_Wdata(s_M_GRF_Wdata),
        .W_we(W_we), .W_A3(W_A3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: history of instructions that entered E, each tagged with the
    // cycle it entered. Age 0/1/2 = E/M/W; readiness is Tnew minus age.
    typedef struct {
        int ent; int a3; int rs; int rt; int tnew; int src;
    } inst_t;

    inst_t hist[$];
    int    cyc = 0;

    function automatic bit find(input int age, output inst_t it);
        it = '{0, 0, 0, 0, 0, 0};
        foreach (hist[i]) if (cyc - hist[i].ent == age) begin
            it = hist[i];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int remaining(input inst_t it, input int age);
        return (it.tnew > age) ? it.tnew - age : 0;
    endfunction

    function automatic bit m_stall();
        inst_t it;
        if (!D_valid) return 1'b0;
        for (int age = 0; age < 2; age++) begin
            if (find(age, it) && it.a3 != 0) begin
                if (it.a3 == int'(D_rs) && int'(D_Tuse_rs) < remaining(it, age)) return 1'b1;
                if (it.a3 == int'(D_rt) && int'(D_Tuse_rt) < remaining(it, age)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int m_fwd(input int r, input int first_age);
        inst_t it;
        if (r == 0) return 0;
        for (int age = first_age; age <= 2; age++) begin
            if (find(age, it) && it.a3 == r)
                return (age == 2 || remaining(it, age) == 0) ? age + 1 : 0;
        end
        return 0;
    endfunction

    function automatic int m_fwd_e(input bit use_rt);
        inst_t c;
        if (!find(0, c)) return 0;
        return m_fwd(use_rt ? c.rt : c.rs, 1);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist.delete();
        end else begin
            bit enter;
            enter = D_valid && !m_stall();
            cyc++;
            if (enter)
                hist.push_back('{cyc, int'(D_A3), int'(D_rs), int'(D_rt), int'(D_Tnew), int'(D_src)});
            while (hist.size() > 0 && cyc - hist[0].ent > 2) void'(hist.pop_front());
        end
    end

    // Single compare process: every output against the model, every cycle.
    always @(negedge clk) begin
        inst_t m, w;
        bit hm, hw;
        hm = find(1, m);
        hw = find(2, w);
        chk("m_stall",    int'(stall),         int'(m_stall()));
        chk("m_fwd_D_rs", int'(fwd_D_rs),      m_fwd(int'(D_rs), 0));
        chk("m_fwd_D_rt", int'(fwd_D_rt),      m_fwd(int'(D_rt), 0));
        chk("m_fwd_E_rs", int'(fwd_E_rs),      m_fwd_e(1'b0));
        chk("m_fwd_E_rt", int'(fwd_E_rt),      m_fwd_e(1'b1));
        chk("m_s_M",      int'(s_M_GRF_Wdata), hm ? m.src : 0);
        chk("m_W_we",     int'(W_we),          (hw && w.a3 != 0) ? 1 : 0);
        chk("m_W_A3",     int'(W_A3),          hw ? w.a3 : 0);
    end

    task automatic ins(input int rs, input int rt, input int trs, input int trt,
                       input int a3, input int tnew, input int src);
        D_valid = 1'b1; D_rs = 5'(rs); D_rt = 5'(rt);
        D_Tuse_rs = 2'(trs); D_Tuse_rt = 2'(trt);
        D_A3 = 5'(a3); D_Tnew = 2'(tnew); D_src = 2'(src);
    endtask

    task automatic bub();
        D_valid = 1'b0; D_rs = '0; D_rt = '0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
        D_A3 = '0; D_Tnew = '0; D_src = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drain();
        bub();
        repeat (3) tick();
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        at_neg();
        chk("rst_stall", int'(stall), 0);
        chk("rst_W_we", int'(W_we), 0);
        chk("rst_fwd_E_rs", int'(fwd_E_rs), 0);
        tick();
        reset = 1'b1;
        tick();

        // Load-use: lw $8 then addu $10,$8,$9
        ins(29, 0, 1, 3, 8, 2, 1); tick();
        ins(8, 9, 1, 1, 10, 1, 0);
        at_neg(); chk("lu_stall_1", int'(stall), 1); tick();
        at_neg(); chk("lu_stall_2", int'(stall), 0); tick();
        bub();
        at_neg(); chk("lu_fwd_E_rs", int'(fwd_E_rs), 3);
        chk("lu_W_A3", int'(W_A3), 8); tick();
        drain();

        // ALU result feeding a branch
        ins(1, 2, 1, 1, 9, 1, 0); tick();
        ins(9, 0, 0, 0, 0, 0, 0);
        at_neg(); chk("br_stall_1", int'(stall), 1); tick();
        at_neg(); chk("br_stall_2", int'(stall), 0);
        chk("br_fwd_D_rs", int'(fwd_D_rs), 2);
        chk("br_s_M", int'(s_M_GRF_Wdata), 0); tick();
        drain();

        // jal then jr $31
        ins(0, 0, 3, 3, 31, 0, 2); tick();
        ins(31, 0, 0, 3, 0, 0, 0);
        at_neg(); chk("jal_stall", int'(stall), 0);
        chk("jal_fwd_D_rs", int'(fwd_D_rs), 1); tick();
        bub();
        at_neg(); chk("jal_s_M", int'(s_M_GRF_Wdata), 2); tick();
        at_neg(); chk("jal_W_we", int'(W_we), 1);
        chk("jal_W_A3", int'(W_A3), 31); tick();
        drain();

        // $0 destination
        ins(29, 0, 1, 3, 0, 2, 1); tick();
        ins(0, 0, 1, 1, 11, 1, 0);
        at_neg(); chk("z_stall", int'(stall), 0);
        chk("z_fwd_D_rs", int'(fwd_D_rs), 0); tick();
        bub();
        at_neg(); chk("z_fwd_E_rs", int'(fwd_E_rs), 0); tick();
        at_neg(); chk("z_W_we", int'(W_we), 0); tick();
        drain();

        // E beats M on the same register
        ins(1, 2, 1, 1, 5, 1, 0); tick();
        ins(3, 0, 1, 3, 5, 1, 0); tick();
        ins(5, 0, 1, 3, 6, 1, 0);
        at_neg(); chk("pri_stall", int'(stall), 0);
        chk("pri_fwd_D_rs_E", int'(fwd_D_rs), 0); tick();
        at_neg(); chk("pri_fwd_D_rs_M", int'(fwd_D_rs), 2);
        chk("pri_fwd_E_rs", int'(fwd_E_rs), 2); tick();
        drain();

        // Asynchronous reset during a load-use stall
        ins(29, 0, 1, 3, 8, 2, 1); tick();
        ins(8, 0, 1, 3, 10, 1, 0);
        at_neg(); chk("ar_stall_pre", int'(stall), 1);
        #2 reset = 1'b0;
        #1 chk("ar_stall_drop", int'(stall), 0);
        chk("ar_W_we", int'(W_we), 0);
        @(posedge clk); #1 reset = 1'b1;
        ins(0, 0, 3, 3, 31, 0, 2);
        at_neg(); chk("ar_post_stall", int'(stall), 0); tick();
        ins(31, 0, 0, 3, 0, 0, 0);
        at_neg(); chk("ar_post_fwd_D_rs", int'(fwd_D_rs), 1); tick();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
